// File: rtl/alu_share_arbiter_pkg.sv
// ALU definitions shared by the arbiter top: op encodings {funct3, funct7[5]},
// legality check and the single-cycle combinational ALU function.
package alu_share_arbiter_pkg;

  localparam int ALU_W = 32;
  localparam int SH_W  = $clog2(ALU_W);

  localparam logic [3:0] OP_ADD  = 4'b0000;
  localparam logic [3:0] OP_XOR  = 4'b1000;
  localparam logic [3:0] OP_OR   = 4'b1100;
  localparam logic [3:0] OP_AND  = 4'b1110;
  localparam logic [3:0] OP_SLL  = 4'b0010;
  localparam logic [3:0] OP_SRL  = 4'b1010;
  localparam logic [3:0] OP_SRA  = 4'b1011;
  localparam logic [3:0] OP_SLT  = 4'b0100;
  localparam logic [3:0] OP_SLTU = 4'b0110;

  typedef struct packed {
    logic [ALU_W-1:0] data;
    logic             illegal;
  } alu_res_t;

  function automatic logic is_legal_alu_op(input logic [3:0] sel);
    case (sel)
      OP_ADD, OP_XOR, OP_OR, OP_AND, OP_SLL,
      OP_SRL, OP_SRA, OP_SLT, OP_SLTU: return 1'b1;
      default:                         return 1'b0;
    endcase
  endfunction

  // Shifts look at the whole of operand B: any amount >= ALU_W clears the
  // result, or fills it with the sign bit for SRA.
  function automatic alu_res_t alu_compute(input logic [ALU_W-1:0] a,
                                           input logic [ALU_W-1:0] b,
                                           input logic [3:0]       sel);
    alu_res_t r;
    logic     big_shift;
    big_shift = |b[ALU_W-1:SH_W];
    r.illegal = ~is_legal_alu_op(sel);
    r.data    = '0;
    case (sel)
      OP_ADD:  r.data = a + b;
      OP_XOR:  r.data = a ^ b;
      OP_OR:   r.data = a | b;
      OP_AND:  r.data = a & b;
      OP_SLL:  r.data = big_shift ? '0 : (a << b[SH_W-1:0]);
      OP_SRL:  r.data = big_shift ? '0 : (a >> b[SH_W-1:0]);
      OP_SRA:  r.data = big_shift ? {ALU_W{a[ALU_W-1]}}
                                  : ALU_W'($signed(a) >>> b[SH_W-1:0]);
      OP_SLT:  r.data = {{(ALU_W-1){1'b0}}, ($signed(a) < $signed(b))};
      OP_SLTU: r.data = {{(ALU_W-1){1'b0}}, (a < b)};
      default: r.data = '0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/alu_share_arbiter_rr_arbiter.sv
// Combinational round-robin picker: rotate eligibility so the pointer sits at
// bit 0, take the lowest set bit, rotate the one-hot result back.
module alu_share_arbiter_rr_arbiter
  import alu_share_arbiter_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int PTR_W   = 1
) (
  input  logic [NUM_REQ-1:0] elig,
  input  logic [PTR_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] grant
);

  logic [NUM_REQ-1:0] rot;
  logic [NUM_REQ-1:0] pick;
  logic               found;

  always_comb begin
    rot   = NUM_REQ'({elig, elig} >> ptr);
    pick  = '0;
    found = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (rot[k] && !found) begin
        pick[k] = 1'b1;
        found   = 1'b1;
      end
    end
    grant = NUM_REQ'(({pick, pick} << ptr) >> NUM_REQ);
  end

endmodule

// File: rtl/alu_share_arbiter.sv
// One shared ALU serving NUM_REQ valid/ready requesters through a round-robin
// arbiter; each requester owns a one-entry result slot held until accepted.
module alu_share_arbiter
  import alu_share_arbiter_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int TAG_W   = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_REQ-1:0]       in_req_valid,
  output logic [NUM_REQ-1:0]       out_req_ready,
  input  logic [NUM_REQ*ALU_W-1:0] in_req_data1,
  input  logic [NUM_REQ*ALU_W-1:0] in_req_data2,
  input  logic [NUM_REQ*4-1:0]     in_req_select,
  input  logic [NUM_REQ*TAG_W-1:0] in_req_tag,
  output logic [NUM_REQ-1:0]       out_rsp_valid,
  input  logic [NUM_REQ-1:0]       in_rsp_ready,
  output logic [NUM_REQ*ALU_W-1:0] out_rsp_data,
  output logic [NUM_REQ*TAG_W-1:0] out_rsp_tag,
  output logic [NUM_REQ-1:0]       out_rsp_illegal,
  output logic [15:0]              out_conflict_cnt
);

  localparam int PTR_W = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0]       rsp_valid_q, rsp_valid_d;
  logic [NUM_REQ*ALU_W-1:0] rsp_data_q, rsp_data_d;
  logic [NUM_REQ*TAG_W-1:0] rsp_tag_q, rsp_tag_d;
  logic [NUM_REQ-1:0]       rsp_illegal_q, rsp_illegal_d;
  logic [PTR_W-1:0]         ptr_q, ptr_d;
  logic [15:0]              conflict_cnt_q, conflict_cnt_d;

  logic [NUM_REQ-1:0] elig;
  logic [NUM_REQ-1:0] grant;
  logic [2:0]         elig_cnt;
  logic [PTR_W-1:0]   winner;
  logic [ALU_W-1:0]   op_a, op_b;
  logic [3:0]         op_sel;
  logic [TAG_W-1:0]   op_tag;
  alu_res_t           alu_res;

  // A full slot is still eligible if its consumer drains it this cycle.
  genvar gi;
  generate
    for (gi = 0; gi < NUM_REQ; gi++) begin : g_elig
      assign elig[gi] = in_req_valid[gi] & (~rsp_valid_q[gi] | in_rsp_ready[gi]);
    end
  endgenerate

  alu_share_arbiter_rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .PTR_W   (PTR_W)
  ) u_rr (
    .elig  (elig),
    .ptr   (ptr_q),
    .grant (grant)
  );

  assign out_req_ready = grant;

  // Grant is one-hot, so an AND-OR mux selects the operands without priority.
  always_comb begin
    op_a   = '0;
    op_b   = '0;
    op_sel = '0;
    op_tag = '0;
    winner = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      op_a   |= in_req_data1[ALU_W*i +: ALU_W] & {ALU_W{grant[i]}};
      op_b   |= in_req_data2[ALU_W*i +: ALU_W] & {ALU_W{grant[i]}};
      op_sel |= in_req_select[4*i +: 4]        & {4{grant[i]}};
      op_tag |= in_req_tag[TAG_W*i +: TAG_W]   & {TAG_W{grant[i]}};
      winner |= PTR_W'(i) & {PTR_W{grant[i]}};
    end
    alu_res = alu_compute(op_a, op_b, op_sel);
  end

  always_comb begin
    rsp_valid_d   = rsp_valid_q;
    rsp_data_d    = rsp_data_q;
    rsp_tag_d     = rsp_tag_q;
    rsp_illegal_d = rsp_illegal_q;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant[i]) begin
        rsp_valid_d[i]                  = 1'b1;
        rsp_data_d[ALU_W*i +: ALU_W]    = alu_res.data;
        rsp_tag_d[TAG_W*i +: TAG_W]     = op_tag;
        rsp_illegal_d[i]                = alu_res.illegal;
      end else if (in_rsp_ready[i]) begin
        rsp_valid_d[i] = 1'b0;
      end
    end
  end

  always_comb begin
    ptr_d = ptr_q;
    if (|grant) begin
      ptr_d = (winner == PTR_W'(NUM_REQ - 1)) ? '0 : winner + PTR_W'(1);
    end
    elig_cnt = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      elig_cnt = elig_cnt + 3'(elig[i]);
    end
    conflict_cnt_d = conflict_cnt_q;
    if (elig_cnt >= 3'd2 && conflict_cnt_q != 16'hFFFF) begin
      conflict_cnt_d = conflict_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rsp_valid_q    <= '0;
      rsp_data_q     <= '0;
      rsp_tag_q      <= '0;
      rsp_illegal_q  <= '0;
      ptr_q          <= '0;
      conflict_cnt_q <= '0;
    end else begin
      rsp_valid_q    <= rsp_valid_d;
      rsp_data_q     <= rsp_data_d;
      rsp_tag_q      <= rsp_tag_d;
      rsp_illegal_q  <= rsp_illegal_d;
      ptr_q          <= ptr_d;
      conflict_cnt_q <= conflict_cnt_d;
    end
  end

  assign out_rsp_valid    = rsp_valid_q;
  assign out_rsp_data     = rsp_data_q;
  assign out_rsp_tag      = rsp_tag_q;
  assign out_rsp_illegal  = rsp_illegal_q;
  assign out_conflict_cnt = conflict_cnt_q;

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Scoreboard bench: a behavioural model predicts grants, slot occupancy and
// the conflict count; expected results are queued and popped by a monitor.
module tb_alu_share_arbiter;

  localparam int N  = 2;
  localparam int TW = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic [N-1:0]      in_req_valid, out_req_ready, out_rsp_valid, in_rsp_ready, out_rsp_illegal;
  logic [N*32-1:0]   in_req_data1, in_req_data2, out_rsp_data;
  logic [N*4-1:0]    in_req_select;
  logic [N*TW-1:0]   in_req_tag, out_rsp_tag;
  logic [15:0]       out_conflict_cnt;

  always #5 clk = ~clk;

  alu_share_arbiter #(.NUM_REQ(N), .TAG_W(TW)) dut (
    .clk              (clk),
    .rst              (rst),
    .in_req_valid     (in_req_valid),
    .out_req_ready    (out_req_ready),
    .in_req_data1     (in_req_data1),
    .in_req_data2     (in_req_data2),
    .in_req_select    (in_req_select),
    .in_req_tag       (in_req_tag),
    .out_rsp_valid    (out_rsp_valid),
    .in_rsp_ready     (in_rsp_ready),
    .out_rsp_data     (out_rsp_data),
    .out_rsp_tag      (out_rsp_tag),
    .out_rsp_illegal  (out_rsp_illegal),
    .out_conflict_cnt (out_conflict_cnt)
  );

  typedef struct {
    logic [31:0]   data;
    logic [TW-1:0] tag;
    logic          ill;
  } exp_t;

  exp_t          exp_q[N][$];
  bit            pend[N];
  logic [31:0]   pa[N], pb[N];
  logic [3:0]    ps[N];
  logic [TW-1:0] pt[N];
  bit            rdy[N];
  bit            m_full[N];
  int            m_ptr, m_cnt;
  int            tests = 0, fails = 0;
  logic [3:0]    op_tab[9] = '{4'b0000, 4'b1000, 4'b1100, 4'b1110, 4'b0010,
                               4'b1010, 4'b1011, 4'b0100, 4'b0110};

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    tests++;
    if (act !== expv) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, expv, $time);
    end
  endtask

  // Reference ALU written with native operators: SV already gives 0 for
  // over-wide logical shifts and sign-fill for over-wide arithmetic shifts.
  function automatic exp_t ref_op(input logic [31:0] a, input logic [31:0] b,
                                  input logic [3:0] sel, input logic [TW-1:0] tag);
    exp_t r;
    logic signed [31:0] sa;
    sa    = a;
    r.tag = tag;
    r.ill = 1'b0;
    case (sel)
      4'b0000: r.data = a + b;
      4'b1000: r.data = a ^ b;
      4'b1100: r.data = a | b;
      4'b1110: r.data = a & b;
      4'b0010: r.data = a << b;
      4'b1010: r.data = a >> b;
      4'b1011: r.data = sa >>> b;
      4'b0100: r.data = (sa < $signed(b)) ? 32'd1 : 32'd0;
      4'b0110: r.data = (a < b) ? 32'd1 : 32'd0;
      default: begin r.data = 32'd0; r.ill = 1'b1; end
    endcase
    return r;
  endfunction

  task automatic issue(input int i, input logic [31:0] a, input logic [31:0] b,
                       input logic [3:0] s, input logic [TW-1:0] t);
    pend[i] = 1'b1; pa[i] = a; pb[i] = b; ps[i] = s; pt[i] = t;
  endtask

  task automatic issue_rand(input int i);
    logic [31:0] b;
    logic [3:0]  s;
    b = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 40)) : $urandom;
    s = ($urandom_range(0, 4) == 0) ? 4'($urandom) : op_tab[$urandom_range(0, 8)];
    issue(i, $urandom, b, s, TW'($urandom));
  endtask

  task automatic drive();
    for (int i = 0; i < N; i++) begin
      in_req_valid[i]            = pend[i];
      in_req_data1[32*i +: 32]   = pa[i];
      in_req_data2[32*i +: 32]   = pb[i];
      in_req_select[4*i +: 4]    = ps[i];
      in_req_tag[TW*i +: TW]     = pt[i];
      in_rsp_ready[i]            = rdy[i];
    end
  endtask

  // One cycle: drive at the falling edge, check, then advance the model
  // across the coming rising edge.
  task automatic step();
    logic [N-1:0] elig, grant, mf;
    int           idx;
    @(negedge clk);
    drive();
    #1;
    elig  = '0;
    grant = '0;
    for (int i = 0; i < N; i++) begin
      elig[i] = pend[i] && (!m_full[i] || rdy[i]);
      mf[i]   = m_full[i];
    end
    for (int k = 0; k < N; k++) begin
      idx = (m_ptr + k) % N;
      if (grant == '0 && elig[idx]) grant[idx] = 1'b1;
    end
    chk("req_ready", 32'(out_req_ready), 32'(grant));
    chk("rsp_valid", 32'(out_rsp_valid), 32'(mf));
    chk("conflict_cnt", 32'(out_conflict_cnt), 32'(m_cnt));
    if ($countones(elig) >= 2 && m_cnt < 65535) m_cnt++;
    for (int i = 0; i < N; i++) begin
      if (grant[i]) begin
        exp_q[i].push_back(ref_op(pa[i], pb[i], ps[i], pt[i]));
        m_full[i] = 1'b1;
        pend[i]   = 1'b0;
        m_ptr     = (i + 1) % N;
      end else if (rdy[i]) begin
        m_full[i] = 1'b0;
      end
    end
  endtask

  task automatic drain(input int cycles);
    for (int i = 0; i < N; i++) rdy[i] = 1'b1;
    repeat (cycles) step();
  endtask

  task automatic alu_case(input string nm, input logic [31:0] a, input logic [31:0] b,
                          input logic [3:0] s, input logic [31:0] expd, input logic expi);
    rdy[0] = 1'b1;
    issue(0, a, b, s, 4'h5);
    step();
    step();
    chk(nm, out_rsp_data[31:0], expd);
    chk({nm, "_ill"}, 32'(out_rsp_illegal[0]), 32'(expi));
  endtask

  task automatic random_phase(input int cycles);
    repeat (cycles) begin
      for (int i = 0; i < N; i++) begin
        if (!pend[i] && $urandom_range(0, 99) < 60) issue_rand(i);
        rdy[i] = ($urandom_range(0, 99) < 70);
      end
      step();
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    #2;
    if (!rst) begin
      for (int i = 0; i < N; i++) begin
        if (out_rsp_valid[i] && in_rsp_ready[i]) begin
          if (exp_q[i].size() == 0) begin
            chk("unexpected_rsp", 32'(i), 32'hFFFF_FFFF);
          end else begin
            e = exp_q[i].pop_front();
            chk("rsp_data", out_rsp_data[32*i +: 32], e.data);
            chk("rsp_tag", 32'(out_rsp_tag[TW*i +: TW]), 32'(e.tag));
            chk("rsp_illegal", 32'(out_rsp_illegal[i]), 32'(e.ill));
          end
        end
      end
    end
  end

  initial begin
    rst = 1'b1;
    m_ptr = 0;
    m_cnt = 0;
    for (int i = 0; i < N; i++) begin
      pend[i] = 1'b0; rdy[i] = 1'b1; m_full[i] = 1'b0;
      pa[i] = '0; pb[i] = '0; ps[i] = '0; pt[i] = '0;
    end
    issue(0, 32'd7, 32'd5, 4'b0000, 4'd3);
    issue(1, 32'd100, 32'd1, 4'b0000, 4'd1);
    drive();
    repeat (3) @(posedge clk);
    #1;
    chk("reset_rsp_valid", 32'(out_rsp_valid), 32'd0);
    chk("reset_rsp_data", out_rsp_data[31:0] | out_rsp_data[63:32], 32'd0);
    chk("reset_rsp_tag", 32'(out_rsp_tag), 32'd0);
    chk("reset_rsp_illegal", 32'(out_rsp_illegal), 32'd0);
    chk("reset_conflict", 32'(out_conflict_cnt), 32'd0);
    @(posedge clk);
    #2 rst = 1'b0;

    step();
    chk("first_grant_req0", 32'(out_req_ready), 32'd1);
    step();
    chk("second_grant_req1", 32'(out_req_ready), 32'd2);
    chk("add_data", out_rsp_data[31:0], 32'd12);
    chk("add_tag", 32'(out_rsp_tag[3:0]), 32'd3);
    chk("add_illegal", 32'(out_rsp_illegal[0]), 32'd0);

    repeat (8) begin
      for (int i = 0; i < N; i++) if (!pend[i]) issue_rand(i);
      step();
    end

    drain(4);
    rdy[1] = 1'b0;
    issue(1, 32'hDEAD0000, 32'h0000BEEF, 4'b1100, 4'd9);
    step();
    issue(1, 32'd1, 32'd2, 4'b0000, 4'd2);
    repeat (6) begin
      if (!pend[0]) issue_rand(0);
      step();
      chk("held_data1", out_rsp_data[63:32], 32'hDEADBEEF);
    end
    if (!pend[0]) issue_rand(0);
    rdy[1] = 1'b1;
    step();
    chk("refill_grant_req1", 32'(out_req_ready), 32'd2);
    drain(4);

    alu_case("sra", 32'h80000000, 32'd4, 4'b1011, 32'hF8000000, 1'b0);
    alu_case("sltu", 32'd1, 32'hFFFFFFFF, 4'b0110, 32'd1, 1'b0);
    alu_case("slt", 32'hFFFFFFFF, 32'd1, 4'b0100, 32'd1, 1'b0);
    alu_case("illegal", 32'd3, 32'd4, 4'b0001, 32'd0, 1'b1);
    alu_case("sll_32", 32'hFFFFFFFF, 32'd32, 4'b0010, 32'd0, 1'b0);
    alu_case("sra_big", 32'h80000000, 32'd40, 4'b1011, 32'hFFFFFFFF, 1'b0);
    drain(3);

    random_phase(1500);
    drain(4);

    rdy[0] = 1'b0;
    issue(0, 32'd11, 32'd22, 4'b0000, 4'd7);
    step();
    step();
    issue(1, 32'd33, 32'd44, 4'b0000, 4'd8);
    rdy[1] = 1'b1;
    @(negedge clk);
    drive();
    #3 rst = 1'b1;
    #1;
    chk("async_rst_valid", 32'(out_rsp_valid), 32'd0);
    chk("async_rst_conflict", 32'(out_conflict_cnt), 32'd0);
    m_ptr = 0;
    m_cnt = 0;
    for (int i = 0; i < N; i++) begin
      pend[i] = 1'b0; m_full[i] = 1'b0; rdy[i] = 1'b1;
      exp_q[i].delete();
    end
    drive();
    repeat (2) @(posedge clk);
    #2 rst = 1'b0;
    issue(0, 32'd5, 32'd6, 4'b1000, 4'd1);
    issue(1, 32'd7, 32'd8, 4'b1110, 4'd2);
    step();
    chk("post_rst_grant_req0", 32'(out_req_ready), 32'd1);

    random_phase(300);
    drain(5);
    for (int i = 0; i < N; i++) chk("queue_empty", 32'(exp_q[i].size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
